// File: rtl/subleq_pc_stack.sv
// Program counter for the SUBLEQ machine: step/load/relative-branch plus a small
// call/return stack with sticky overflow, underflow and illegal-op flags.
module subleq_pc_stack #(
   parameter int AW        = 8,
   parameter int STEP      = 3,
   parameter int DEPTH     = 4,
   parameter int RESET_VEC = 0
) (
   input  logic                         clk,
   input  logic                         res,
   input  logic                         en,
   input  logic [2:0]                   mod,
   input  logic [AW-1:0]                inp,
   input  logic                         clr_err,
   output logic [AW-1:0]                out,
   output logic [AW-1:0]                tos,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty,
   output logic                         ovf_err,
   output logic                         unf_err,
   output logic                         ill_err
);

   localparam int DW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   localparam logic [2:0] MOD_HOLD = 3'd0;
   localparam logic [2:0] MOD_INC  = 3'd1;
   localparam logic [2:0] MOD_LOAD = 3'd2;
   localparam logic [2:0] MOD_REL  = 3'd3;
   localparam logic [2:0] MOD_CALL = 3'd4;
   localparam logic [2:0] MOD_RET  = 3'd5;

   logic [AW-1:0] out_q, out_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          ill_q, ill_d;
   logic [AW-1:0] stack_q [DEPTH];

   logic          full_w, empty_w;
   logic [IW-1:0] top_idx, push_idx;
   logic [AW-1:0] tos_w;
   logic [AW-1:0] step_w;
   logic          push_en;
   logic [AW-1:0] push_data;
   logic          ovf_set, unf_set, ill_set;

   assign step_w   = AW'(STEP);
   assign full_w   = (depth_q == DW'(DEPTH));
   assign empty_w  = (depth_q == '0);
   assign top_idx  = IW'(depth_q - DW'(1));
   assign push_idx = IW'(depth_q);
   // Empty stack reads as zero so stale RAM contents never leak out.
   assign tos_w    = empty_w ? '0 : stack_q[top_idx];

   always_comb begin
      out_d     = out_q;
      depth_d   = depth_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      ill_d     = ill_q;
      push_en   = 1'b0;
      push_data = '0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      ill_set   = 1'b0;
      if (en) begin
         case (mod)
            MOD_HOLD: ;
            MOD_INC:  out_d = out_q + step_w;
            MOD_LOAD: out_d = inp;
            MOD_REL:  out_d = out_q + inp;
            MOD_CALL: begin
               if (full_w) begin
                  ovf_set = 1'b1;
               end else begin
                  push_en   = 1'b1;
                  push_data = out_q + step_w;
                  out_d     = inp;
                  depth_d   = depth_q + DW'(1);
               end
            end
            MOD_RET: begin
               if (empty_w) begin
                  unf_set = 1'b1;
               end else begin
                  out_d   = tos_w;
                  depth_d = depth_q - DW'(1);
               end
            end
            default: ill_set = 1'b1;
         endcase
         // A fresh error in the clearing cycle still lands.
         ovf_d = (ovf_q & ~clr_err) | ovf_set;
         unf_d = (unf_q & ~clr_err) | unf_set;
         ill_d = (ill_q & ~clr_err) | ill_set;
      end
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         out_q   <= AW'(RESET_VEC);
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         ill_q   <= ill_d;
      end
   end

   always_ff @(posedge clk) begin
      if (res && push_en) begin
         stack_q[push_idx] <= push_data;
      end
   end

   assign out     = out_q;
   assign tos     = tos_w;
   assign depth   = depth_q;
   assign full    = full_w;
   assign empty   = empty_w;
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
   assign ill_err = ill_q;

endmodule
